// File: rtl/img_pkg.sv
// Shared types and luma weights for the pixel-recolouring path.
package img_pkg;

  typedef logic [11:0] rgb444_t;
  typedef logic [3:0]  pal_idx_t;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_GRAY    = 2'b01,
    MODE_PAL     = 2'b10,
    MODE_PAL_INV = 2'b11
  } colorize_mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  localparam logic [15:0] LUMA_WR = 16'd51;
  localparam logic [15:0] LUMA_WG = 16'd179;
  localparam logic [15:0] LUMA_WB = 16'd26;

  // Weights sum to 256, so the top nibble of the 16-bit sum is a 4-bit luma.
  function automatic pal_idx_t luma_idx(input rgb444_t rgb);
    logic [15:0] r8;
    logic [15:0] g8;
    logic [15:0] b8;
    logic [15:0] sum;
    r8  = {8'h00, rgb[11:8], rgb[11:8]};
    g8  = {8'h00, rgb[7:4],  rgb[7:4]};
    b8  = {8'h00, rgb[3:0],  rgb[3:0]};
    sum = r8 * LUMA_WR + g8 * LUMA_WG + b8 * LUMA_WB;
    return pal_idx_t'(sum >> 12);
  endfunction

endpackage

// File: rtl/img_luma4.sv
// Registered RGB444 -> 4-bit luma index, one clock of latency.
module img_luma4
  import img_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_rgb,
  output logic [3:0]  o_idx
);

  logic [3:0] w_idx;
  logic [3:0] r_idx_p1;

  assign w_idx = luma_idx(i_rgb);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_idx_p1 <= '0;
    else       r_idx_p1 <= w_idx;
  end

  assign o_idx = r_idx_p1;

endmodule

// File: rtl/img_colorizer.sv
// Two-stage pseudo-colour stage: luma index through a 16-entry palette whose
// updates are double-buffered and applied only on a vertical-sync edge.
module img_colorizer
  import img_pkg::*;
#(
  parameter logic       VSYNC_ACTIVE = 1'b0,
  parameter logic [1:0] DEFAULT_MODE = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DE,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [11:0] rgb_in,
  input  logic [1:0]  mode,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [11:0] pal_wdata,
  input  logic        pal_commit,
  output logic        pal_pending,
  output logic        DE_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [11:0] rgb_out
);

  logic [11:0]    r_rgb_p1;
  logic           r_de_p1;
  logic           r_hs_p1;
  logic           r_vs_p1;
  colorize_mode_e r_mode_p1;
  logic [3:0]     w_idx_p1;

  logic [11:0]    r_rgb_p2;
  logic           r_de_p2;
  logic           r_hs_p2;
  logic           r_vs_p2;
  logic [11:0]    w_pix_p1;

  logic [11:0]    r_shadow [16];
  logic [11:0]    r_active [16];

  commit_state_e  r_state;
  commit_state_e  w_state_nxt;
  logic           w_vs_edge;
  logic           w_copy;
  logic           w_pending;

  // ---- stage 1: luma index plus aligned pixel, control and syncs
  img_luma4 u_luma (
    .i_clk (clk),
    .i_rst (reset),
    .i_rgb (rgb_in),
    .o_idx (w_idx_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb_p1  <= '0;
      r_de_p1   <= 1'b0;
      r_hs_p1   <= 1'b1;
      r_vs_p1   <= ~VSYNC_ACTIVE;
      r_mode_p1 <= colorize_mode_e'(DEFAULT_MODE);
    end else begin
      r_rgb_p1  <= rgb_in;
      r_de_p1   <= DE;
      r_hs_p1   <= h_sync_in;
      r_vs_p1   <= v_sync_in;
      r_mode_p1 <= colorize_mode_e'(mode);
    end
  end

  // ---- stage 2: mode select and palette lookup
  always_comb begin
    w_pix_p1 = 12'h000;
    if (r_de_p1) begin
      case (r_mode_p1)
        MODE_BYPASS:  w_pix_p1 = r_rgb_p1;
        MODE_GRAY:    w_pix_p1 = {w_idx_p1, w_idx_p1, w_idx_p1};
        MODE_PAL:     w_pix_p1 = r_active[w_idx_p1];
        MODE_PAL_INV: w_pix_p1 = r_active[~w_idx_p1];
        default:      w_pix_p1 = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb_p2 <= 12'h000;
      r_de_p2  <= 1'b0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= ~VSYNC_ACTIVE;
    end else begin
      r_rgb_p2 <= w_pix_p1;
      r_de_p2  <= r_de_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
    end
  end

  assign rgb_out    = r_rgb_p2;
  assign DE_out     = r_de_p2;
  assign h_sync_out = r_hs_p2;
  assign v_sync_out = r_vs_p2;

  // The stage-1 vsync register doubles as the previous sample for edge detection.
  assign w_vs_edge = (r_vs_p1 != VSYNC_ACTIVE) && (v_sync_in == VSYNC_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (pal_commit) w_state_nxt = ST_PENDING;
      ST_PENDING: if (w_vs_edge)  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pending = (r_state == ST_PENDING);
    w_copy    = w_pending && w_vs_edge;
  end

  assign pal_pending = w_pending;

  // Copy samples the shadow before any same-edge write lands in it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= {4'(i), 4'(i), 4'(i)};
        r_active[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else begin
      if (pal_we) r_shadow[pal_addr] <= pal_wdata;
      if (w_copy) begin
        for (int i = 0; i < 16; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_img_colorizer.sv
// Scoreboard bench for img_colorizer: directed pixels with hand-computed results.
module tb_img_colorizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        DE = 1'b0;
  logic        h_sync_in = 1'b1;
  logic        v_sync_in = 1'b1;
  logic [11:0] rgb_in = 12'h000;
  logic [1:0]  mode = 2'b10;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'h0;
  logic [11:0] pal_wdata = 12'h000;
  logic        pal_commit = 1'b0;
  logic        pal_pending;
  logic        DE_out;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [11:0] rgb_out;

  img_colorizer dut (
    .clk         (clk),
    .reset       (reset),
    .DE          (DE),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .rgb_in      (rgb_in),
    .mode        (mode),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .pal_commit  (pal_commit),
    .pal_pending (pal_pending),
    .DE_out      (DE_out),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .rgb_out     (rgb_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [14:0] IDLE = {1'b0, 1'b1, 1'b1, 12'h000};

  typedef struct {
    int          due;
    bit          is_pend;
    logic [14:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit          nx_we = 0;
  logic [3:0]  nx_addr = 4'h0;
  logic [11:0] nx_wd = 12'h000;
  bit          nx_commit = 0;
  bit          nx_kill = 0;

  logic [14:0] act;

  // Monitor: compares every expectation that falls due on this cycle.
  always @(posedge clk) begin
    #2;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        if (sb[i].is_pend) act = {14'd0, pal_pending};
        else               act = {DE_out, h_sync_out, v_sync_out, rgb_out};
        n_tests++;
        if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic px(input bit de, input bit hs, input bit vs, input logic [1:0] md,
                    input logic [11:0] rgb, input logic [11:0] exp_rgb,
                    input int pend, input string nm);
    exp_t e;
    @(negedge clk);
    reset      = 1'b0;
    DE         = de;
    h_sync_in  = hs;
    v_sync_in  = vs;
    mode       = md;
    rgb_in     = rgb;
    pal_we     = nx_we;
    pal_addr   = nx_addr;
    pal_wdata  = nx_wd;
    pal_commit = nx_commit;
    e.due     = cyc + 2;
    e.is_pend = 1'b0;
    e.exp     = nx_kill ? IDLE : {de, hs, vs, exp_rgb};
    e.name    = nm;
    sb.push_back(e);
    if (pend >= 0) begin
      e.due     = cyc + 1;
      e.is_pend = 1'b1;
      e.exp     = 15'(pend);
      e.name    = {nm, "_pend"};
      sb.push_back(e);
    end
    nx_we     = 0;
    nx_commit = 0;
    nx_kill   = 0;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset      = 1'b1;
      DE         = 1'b1;
      h_sync_in  = 1'b1;
      v_sync_in  = 1'b1;
      rgb_in     = 12'hABC;
      pal_we     = 1'b0;
      pal_commit = 1'b0;
      e.due = cyc + 2; e.is_pend = 1'b0; e.exp = IDLE; e.name = "reset_out";
      sb.push_back(e);
      e.due = cyc + 1; e.is_pend = 1'b1; e.exp = 15'd0; e.name = "reset_pend";
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(3);

    // Gray mode
    px(1, 1, 1, 2'b01, 12'hFFF, 12'hFFF, -1, "gray_fff");
    px(1, 1, 1, 2'b01, 12'hF00, 12'h333, -1, "gray_f00");
    px(1, 1, 1, 2'b01, 12'h0F0, 12'hBBB, -1, "gray_0f0");

    // Reset palette is the gray ramp
    px(1, 1, 1, 2'b10, 12'h00F, 12'h111, -1, "pal_00f");
    px(1, 1, 1, 2'b11, 12'h00F, 12'hEEE, -1, "palinv_00f");

    // Blanking in every mode, syncs carried through
    px(0, 0, 1, 2'b00, 12'hABC, 12'h000, -1, "blank_m0");
    px(0, 1, 1, 2'b01, 12'hABC, 12'h000, -1, "blank_m1");
    px(0, 0, 1, 2'b10, 12'hABC, 12'h000, -1, "blank_m2");
    px(0, 0, 0, 2'b11, 12'hABC, 12'h000, -1, "blank_m3");

    px(1, 1, 1, 2'b00, 12'h5A3, 12'h5A3, -1, "bypass_5a3");

    // Commit waits for the vsync edge
    nx_we = 1; nx_addr = 4'd3; nx_wd = 12'h0F0;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 0, "commit_wr");
    nx_commit = 1;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 1, "commit_req");
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 1, "commit_hold1");
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 1, "commit_hold2");
    px(1, 1, 0, 2'b10, 12'hF00, 12'h0F0, 0, "commit_apply");
    px(1, 1, 0, 2'b10, 12'hF00, 12'h0F0, 0, "commit_after1");
    px(1, 1, 1, 2'b10, 12'hF00, 12'h0F0, -1, "commit_after2");

    // Mid-frame reset drops in-flight pixels and the pending commit
    nx_commit = 1;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h0F0, 1, "rst_pre");
    nx_kill = 1;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h0F0, -1, "rst_inflight");
    do_reset(1);
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 0, "rst_ramp");

    // Double commit, write coinciding with the applying edge
    nx_we = 1; nx_addr = 4'd3; nx_wd = 12'h0F0;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 0, "dc_wr");
    nx_commit = 1;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 1, "dc_req1");
    nx_commit = 1;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h333, 1, "dc_req2");
    nx_we = 1; nx_addr = 4'd3; nx_wd = 12'hF0F;
    px(1, 1, 0, 2'b10, 12'hF00, 12'h0F0, 0, "dc_apply");
    px(1, 1, 0, 2'b10, 12'hF00, 12'h0F0, 0, "dc_hold1");
    px(1, 1, 1, 2'b10, 12'hF00, 12'h0F0, 0, "dc_hold2");
    px(1, 1, 0, 2'b10, 12'hF00, 12'h0F0, 0, "dc_noreapply");
    px(1, 1, 1, 2'b10, 12'hF00, 12'h0F0, 0, "dc_hold3");
    nx_commit = 1;
    px(1, 1, 1, 2'b10, 12'hF00, 12'h0F0, 1, "dc_req3");
    px(1, 1, 0, 2'b10, 12'hF00, 12'hF0F, 0, "dc_apply2");
    px(1, 1, 1, 2'b10, 12'hF00, 12'hF0F, -1, "dc_after");

    // Commit on the same cycle as a vsync edge waits for the next edge
    nx_we = 1; nx_addr = 4'd3; nx_wd = 12'h00F;
    px(1, 1, 1, 2'b10, 12'hF00, 12'hF0F, 0, "ce_wr");
    nx_commit = 1;
    px(1, 1, 0, 2'b10, 12'hF00, 12'hF0F, 1, "ce_commit_edge");
    px(1, 1, 1, 2'b10, 12'hF00, 12'hF0F, 1, "ce_wait");
    px(1, 1, 0, 2'b10, 12'hF00, 12'h00F, 0, "ce_apply");
    px(1, 1, 1, 2'b10, 12'hF00, 12'h00F, -1, "ce_after");

    for (int k = 0; k < 3; k++) px(0, 1, 1, 2'b10, 12'h000, 12'h000, -1, "flush");

    for (int k = 0; k < 10; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #3;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/img_colorizer.md
Name: img_colorizer

Overview:
- Pipelined pixel recolouring stage for the VGA path; maps grayscale intensity back to colour.
- Reduces each incoming RGB444 pixel to a 4-bit luma index, then maps that index through a programmable 16-entry RGB444 palette (false colour / pseudo-colour).
- Sits between the image source / line buffer and the VGA output register.
- Syncs are delayed to stay aligned with pixel data.
- Palette updates are double-buffered and take effect only at a vertical-sync boundary, so a frame never tears.

Parameters:
- VSYNC_ACTIVE, default 1'b0: level of v_sync_in during its active pulse (0 = active-low VGA).
- DEFAULT_MODE, default 2'b10: mode selected out of reset.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- DE  in  1  display-enable for rgb_in
- h_sync_in  in  1  horizontal sync, aligned with rgb_in
- v_sync_in  in  1  vertical sync, aligned with rgb_in
- rgb_in  in  12  RGB444 pixel {R[11:8], G[7:4], B[3:0]}
- mode  in  2  00 bypass, 01 gray, 10 palette, 11 inverted-palette
- pal_we  in  1  shadow-palette write strobe
- pal_addr  in  4  shadow-palette entry
- pal_wdata  in  12  RGB444 colour to write
- pal_commit  in  1  one-cycle request to copy shadow palette to active palette
- pal_pending  out  1  commit requested, not yet applied
- DE_out  out  1  DE delayed 2 cycles
- h_sync_out  out  1  h_sync_in delayed 2 cycles
- v_sync_out  out  1  v_sync_in delayed 2 cycles
- rgb_out  out  12  recoloured pixel

Behaviour:
- Reset (sync, active-high), applied on the clock edge:
  - all pipeline registers and DE_out = 0
  - rgb_out = 12'h000
  - h_sync_out / v_sync_out = inactive level (~VSYNC_ACTIVE for v_sync_out; h_sync_out = 1)
  - pal_pending = 0
  - mode register = DEFAULT_MODE
  - shadow and active palette entry i = {i, i, i} (gray ramp)
  - a reset mid-frame discards in-flight pixels and any pending commit.
- Stage 1 (registered):
  - R8/G8/B8 = each nibble replicated to 8 bits.
  - sum[15:0] = R8*51 + G8*179 + B8*26, unsigned. Maximum is 65280, so there is no overflow.
  - idx = sum[15:12].
  - Stage 1 also registers rgb_in, DE, the syncs and mode.
- Stage 2 (registered output):
  - DE1 = 0 → rgb_out = 12'h000, regardless of mode.
  - mode 00 → rgb1, unchanged.
  - mode 01 → {idx, idx, idx}.
  - mode 10 → active_pal[idx].
  - mode 11 → active_pal[15 - idx].
- Latency: exactly 2 clocks, input to output, for data, DE and both syncs. Throughput is 1 pixel/clock with no stall.
- Palette write: when pal_we = 1, shadow[pal_addr] <= pal_wdata on that edge. This is allowed at any time and does not affect the active palette.
- Commit state machine, 2 states:
  - IDLE: pal_commit = 1 → go to PENDING; pal_pending = 1 from the next cycle.
  - PENDING: on a v_sync_in active edge (previous sample inactive, current sample == VSYNC_ACTIVE), copy all 16 shadow entries to active in that cycle, then return to IDLE; pal_pending = 0 on the next cycle.
  - pal_commit while in PENDING: ignored (remains pending).
  - pal_we in the same cycle as the copy: the copy uses shadow contents from before the write; the write lands in shadow only.
  - pal_commit in the same cycle as a vsync active edge while in IDLE: no copy that edge; the next vsync edge applies it.
- A v_sync_in active edge is detected from a registered previous sample. The previous-sample register resets to the inactive level, so no spurious edge follows reset.
- The active palette is read only in stage 2; the copy changes it atomically between two pixel cycles.

Decomposition:
- Package img_pkg:
  - typedef rgb444_t (logic [11:0])
  - enum colorize_mode_e {MODE_BYPASS, MODE_GRAY, MODE_PAL, MODE_PAL_INV}
  - luma weight constants LUMA_WR = 51, LUMA_WG = 179, LUMA_WB = 26
  - typedef pal_idx_t (logic [3:0])
- Sub-module img_luma4: a registered stage-1 luma-index computation (rgb_in → idx, 1-cycle latency). It is reusable by other filters.
- Palette storage and the commit state machine stay in img_colorizer.

Test Plan:
- Mode 01, DE = 1:
  - rgb_in = 12'hFFF → rgb_out = 12'hFFF 2 cycles later.
  - rgb_in = 12'hF00 (sum = 13005 = 0x32CD) → 12'h333.
  - rgb_in = 12'h0F0 (sum = 45645) → 12'hBBB.
- Mode 10 after reset, rgb_in = 12'h00F (sum = 6630 → idx 1) → 12'h111. In mode 11 the same input gives 12'hEEE.
- Commit timing, mode 10, continuous rgb_in = 12'hF00:
  - write shadow[3] = 12'h0F0, pulse pal_commit mid-frame → rgb_out stays 12'h333 and pal_pending = 1.
  - after the v_sync_in active edge → rgb_out = 12'h0F0 (2-cycle latency) and pal_pending = 0.
- DE = 0 with rgb_in = 12'hABC in every mode → rgb_out = 12'h000. DE_out, h_sync_out and v_sync_out match the inputs delayed by exactly 2 cycles.
- Mode 00, rgb_in = 12'h5A3 → 12'h5A3.
- Reset asserted 1 cycle mid-frame after a committed palette change:
  - next cycle rgb_out = 12'h000, pal_pending = 0.
  - after reset, rgb_in = 12'hF00 in mode 10 → 12'h333 (ramp restored).
- pal_commit pulsed twice before a vsync edge, plus pal_we to entry 3 in the same cycle as the vsync edge → a single copy occurs. Active[3] holds the old shadow value, and the new value applies only after another commit + vsync.
